// File: rtl/nearest_centroid_select_if.sv
// Streaming handshake bundle between the distance stage, the arg-min stage and its consumer.
interface nearest_centroid_select_if #(
    parameter int unsigned IW = 2,
    parameter int unsigned DW = 32
);
    logic [DW-1:0] select_dist;
    logic          select_in_valid;
    logic          select_in_ready;
    logic          select_clear;
    logic [IW-1:0] select_idx;
    logic [DW-1:0] select_min;
    logic          select_out_valid;
    logic          select_out_ready;

    modport master (
        output select_dist,
        output select_in_valid,
        input  select_in_ready,
        output select_clear,
        input  select_idx,
        input  select_min,
        input  select_out_valid,
        output select_out_ready
    );

    modport slave (
        input  select_dist,
        input  select_in_valid,
        output select_in_ready,
        input  select_clear,
        output select_idx,
        output select_min,
        output select_out_valid,
        input  select_out_ready
    );
endinterface

// File: rtl/nearest_centroid_select.sv
// Streaming arg-min over K squared distances per point, with a valid/ready output register.
// Optional per-centroid assignment histogram enabled by defining NCS_HIST_EN.
module nearest_centroid_select #(
    parameter int unsigned K  = 4,
    parameter int unsigned IW = 2,
    parameter int unsigned DW = 32
`ifdef NCS_HIST_EN
    ,
    parameter int unsigned CW = 16
`endif
) (
    input  logic                            select_clk,
    input  logic                            select_rst,
    nearest_centroid_select_if.slave        bus
`ifdef NCS_HIST_EN
    ,
    input  logic [IW-1:0]                   select_hist_sel,
    output logic [CW-1:0]                   select_hist_cnt
`endif
);

    typedef enum logic [0:0] {StEmpty, StFull} out_state_e;

    localparam logic [IW-1:0] LastCnt = IW'(K - 1);

    out_state_e    state_q;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] min_q, min_d;
    logic [IW-1:0] out_idx_q;
    logic [DW-1:0] out_min_q;

    logic          in_ready;
    logic          last_beat;
    logic          beat;
    logic          complete;
    logic          take_new;
    logic [IW-1:0] fin_idx;
    logic [DW-1:0] fin_min;

    always_comb begin
        last_beat = (cnt_q == LastCnt);
        // Only the completing beat stalls while a result is still held.
        in_ready  = bus.select_clear ||
                    !((state_q == StFull) && !bus.select_out_ready && last_beat);
        beat      = bus.select_in_valid && in_ready && !bus.select_clear;
        complete  = beat && last_beat;
        take_new  = (cnt_q == '0) || (bus.select_dist < min_q);
        fin_idx   = take_new ? cnt_q : idx_q;
        fin_min   = take_new ? bus.select_dist : min_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        min_d = min_q;
        if (bus.select_clear) begin
            cnt_d = '0;
            idx_d = '0;
            min_d = '0;
        end else if (beat) begin
            cnt_d = last_beat ? '0 : cnt_q + IW'(1);
            idx_d = fin_idx;
            min_d = fin_min;
        end
    end

    always_ff @(posedge select_clk or negedge select_rst) begin
        if (!select_rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            min_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            min_q <= min_d;
        end
    end

    always_ff @(posedge select_clk or negedge select_rst) begin
        if (!select_rst) begin
            state_q   <= StEmpty;
            out_idx_q <= '0;
            out_min_q <= '0;
        end else if (bus.select_clear) begin
            state_q   <= StEmpty;
            out_idx_q <= '0;
            out_min_q <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (complete) begin
                        state_q   <= StFull;
                        out_idx_q <= fin_idx;
                        out_min_q <= fin_min;
                    end
                end
                StFull: begin
                    // A completion in the handshake cycle overwrites and stays full.
                    if (complete) begin
                        out_idx_q <= fin_idx;
                        out_min_q <= fin_min;
                    end else if (bus.select_out_ready) begin
                        state_q <= StEmpty;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign bus.select_in_ready  = in_ready;
    assign bus.select_out_valid = (state_q == StFull);
    assign bus.select_idx       = out_idx_q;
    assign bus.select_min       = out_min_q;

`ifdef NCS_HIST_EN
    logic [CW-1:0] hist_q [K];

    // Counted when a result is loaded, not when it is consumed; saturates at all-ones.
    always_ff @(posedge select_clk or negedge select_rst) begin
        if (!select_rst) begin
            for (int i = 0; i < int'(K); i++) begin
                hist_q[i] <= '0;
            end
        end else if (bus.select_clear) begin
            for (int i = 0; i < int'(K); i++) begin
                hist_q[i] <= '0;
            end
        end else if (complete) begin
            for (int i = 0; i < int'(K); i++) begin
                if ((fin_idx == IW'(i)) && (hist_q[i] != '1)) begin
                    hist_q[i] <= hist_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        select_hist_cnt = '0;
        for (int i = 0; i < int'(K); i++) begin
            if (select_hist_sel == IW'(i)) begin
                select_hist_cnt = hist_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_nearest_centroid_select.sv
// Randomized and directed bench for nearest_centroid_select against a point-level arg-min model.
module tb_nearest_centroid_select;

    localparam int unsigned K  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned DW = 32;
`ifdef NCS_HIST_EN
    localparam int unsigned CW = 3;
`endif

    logic clk;
    logic rst_n;

    nearest_centroid_select_if #(.IW(IW), .DW(DW)) bus ();

`ifdef NCS_HIST_EN
    logic [IW-1:0] hist_sel;
    logic [CW-1:0] hist_cnt;

    nearest_centroid_select #(.K(K), .IW(IW), .DW(DW), .CW(CW)) dut (
        .select_clk      (clk),
        .select_rst      (rst_n),
        .bus             (bus),
        .select_hist_sel (hist_sel),
        .select_hist_cnt (hist_cnt)
    );
`else
    nearest_centroid_select #(.K(K), .IW(IW), .DW(DW)) dut (
        .select_clk (clk),
        .select_rst (rst_n),
        .bus        (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: beats of the current point, the held result, per-centroid counts.
    int unsigned pts[$];
    bit          m_valid;
    int unsigned m_idx;
    int unsigned m_min;
    int unsigned m_hist[K];
    bit          last_acc;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pts.delete();
        m_valid = 1'b0;
        m_idx   = 0;
        m_min   = 0;
        for (int i = 0; i < int'(K); i++) m_hist[i] = 0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit exp_rdy;
        bit acc;
        bit oacc;
`ifdef NCS_HIST_EN
        hist_sel = IW'($urandom_range(0, K - 1));
`endif
        @(negedge clk);
        exp_rdy = bus.select_clear ||
                  !(m_valid && !bus.select_out_ready && pts.size() == int'(K) - 1);
        check_eq("in_ready", 64'(bus.select_in_ready), 64'(exp_rdy));
        check_eq("out_valid", 64'(bus.select_out_valid), 64'(m_valid));
        if (m_valid) begin
            check_eq("out_idx", 64'(bus.select_idx), 64'(m_idx));
            check_eq("out_min", 64'(bus.select_min), 64'(m_min));
        end
`ifdef NCS_HIST_EN
        check_eq("hist_cnt", 64'(hist_cnt), 64'(m_hist[hist_sel]));
`endif
        acc  = bus.select_in_valid && exp_rdy && !bus.select_clear;
        oacc = m_valid && bus.select_out_ready;
        @(posedge clk);
        if (bus.select_clear) begin
            model_reset();
        end else begin
            if (acc) pts.push_back(int'(bus.select_dist));
            if (pts.size() == int'(K)) begin
                m_min = pts[0];
                m_idx = 0;
                for (int i = 1; i < int'(K); i++) begin
                    if (pts[i] < m_min) begin
                        m_min = pts[i];
                        m_idx = i;
                    end
                end
                m_valid = 1'b1;
                if (m_hist[m_idx] < 32'((1 << 3) - 1) || 1'b0) m_hist[m_idx]++;
                pts.delete();
            end else if (oacc) begin
                m_valid = 1'b0;
            end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        bus.select_in_valid = 1'b1;
        bus.select_dist     = d;
        for (int n = 0; n < 50; n++) begin
            cycle();
            if (last_acc) break;
        end
        check_eq("send_accepted", 64'(last_acc), 64'(1));
        bus.select_in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input bit v, input int unsigned idx,
                              input int unsigned mn);
        check_eq({tag, "_valid"}, 64'(bus.select_out_valid), 64'(v));
        check_eq({tag, "_idx"}, 64'(bus.select_idx), 64'(idx));
        check_eq({tag, "_min"}, 64'(bus.select_min), 64'(mn));
    endtask

    initial begin
        rst_n                = 1'b0;
        bus.select_dist      = '0;
        bus.select_in_valid  = 1'b0;
        bus.select_clear     = 1'b0;
        bus.select_out_ready = 1'b1;
`ifdef NCS_HIST_EN
        hist_sel = '0;
`endif
        model_reset();
        last_acc = 1'b0;

        #2;
        expect_out("reset", 1'b0, 0, 0);
        check_eq("reset_in_ready", 64'(bus.select_in_ready), 64'(1));
`ifdef NCS_HIST_EN
        check_eq("reset_hist", 64'(hist_cnt), 64'(0));
`endif
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic point, then result drains with out_ready high.
        send(169); send(6400); send(25); send(900);
        expect_out("basic", 1'b1, 2, 25);
        cycle();
        check_eq("basic_drain", 64'(bus.select_out_valid), 64'(0));

        // Ties resolve to the lower index.
        send(50); send(50); send(50); send(50);
        expect_out("tie_all", 1'b1, 0, 50);
        send(7); send(3); send(3); send(9);
        expect_out("tie_mid", 1'b1, 1, 3);
        cycle();

        // Backpressure: A held, B accumulates, B's last beat stalls.
        bus.select_out_ready = 1'b0;
        send(9); send(4); send(16); send(1);
        expect_out("bp_a", 1'b1, 3, 1);
        send(2); send(8); send(8);
        bus.select_in_valid = 1'b1;
        bus.select_dist     = 8;
        #1;
        check_eq("bp_stall_ready", 64'(bus.select_in_ready), 64'(0));
        cycle();
        cycle();
        check_eq("bp_stall_acc", 64'(last_acc), 64'(0));
        expect_out("bp_hold", 1'b1, 3, 1);
        bus.select_out_ready = 1'b1;
        cycle();
        check_eq("bp_release_acc", 64'(last_acc), 64'(1));
        bus.select_in_valid  = 1'b0;
        bus.select_out_ready = 1'b0;
        expect_out("bp_b", 1'b1, 0, 2);
        cycle();
        expect_out("bp_b_held", 1'b1, 0, 2);

        // Reset mid-point with a result held.
        send(5); send(6);
        #2 rst_n = 1'b0;
        #1;
        expect_out("midrst", 1'b0, 0, 0);
        check_eq("midrst_in_ready", 64'(bus.select_in_ready), 64'(1));
        model_reset();
        #10 rst_n = 1'b1;
        bus.select_out_ready = 1'b1;
        send(30); send(20); send(10); send(40);
        expect_out("after_rst", 1'b1, 2, 10);
        cycle();

        // Clear beats a simultaneous input beat.
        send(11); send(12);
        bus.select_in_valid = 1'b1;
        bus.select_dist     = 1;
        bus.select_clear    = 1'b1;
        cycle();
        bus.select_clear    = 1'b0;
        bus.select_in_valid = 1'b0;
        send(100); send(200); send(3); send(400);
        expect_out("after_clr", 1'b1, 2, 3);
        cycle();

`ifdef NCS_HIST_EN
        bus.select_clear = 1'b1;
        cycle();
        bus.select_clear = 1'b0;
        for (int p = 0; p < 9; p++) begin
            send(40); send(30); send(20); send(10);
        end
        for (int p = 0; p < 2; p++) begin
            send(5); send(1); send(9); send(9);
        end
        hist_sel = 2'd3; #1;
        check_eq("hist3_sat", 64'(hist_cnt), 64'(7));
        hist_sel = 2'd1; #1;
        check_eq("hist1", 64'(hist_cnt), 64'(2));
        hist_sel = 2'd0; #1;
        check_eq("hist0", 64'(hist_cnt), 64'(0));
        bus.select_clear = 1'b1;
        cycle();
        bus.select_clear = 1'b0;
        for (int i = 0; i < int'(K); i++) begin
            hist_sel = IW'(i); #1;
            check_eq("hist_clr", 64'(hist_cnt), 64'(0));
        end
`endif

        // Random traffic with occasional clears and random backpressure.
        for (int n = 0; n < 400; n++) begin
            bus.select_in_valid  = ($urandom_range(0, 3) != 0);
            bus.select_dist      = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 15);
            bus.select_out_ready = ($urandom_range(0, 2) != 0);
            bus.select_clear     = ($urandom_range(0, 49) == 0);
            cycle();
        end
        bus.select_in_valid  = 1'b0;
        bus.select_clear     = 1'b0;
        bus.select_out_ready = 1'b1;
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nearest_centroid_select.md
# nearest_centroid_select

- Streaming arg-min stage directly downstream of `Calculation_distance`.
- Consumes one unsigned 32-bit squared distance per beat: K beats per data point, one per centroid, in centroid order 0..K-1.
- Emits the index of the nearest centroid and that minimum distance through a valid/ready output register.
- Its result drives the K-means cluster-assignment and centroid-update logic.

## Interface
- `K`, 4: centroids per data point, ≥1.
- `IW`, 2: index width; K ≤ 2^IW.
- `DW`, 32: distance width; matches `distance_out`.
- `CW`, 16: histogram counter width (only with `NCS_HIST_EN`).

Ports:
- `select_clk` in 1: clock, rising edge.
- `select_rst` in 1: asynchronous, active-low reset.
- `select_dist` in DW: unsigned distance from the distance stage.
- `select_in_valid` in 1: `select_dist` is valid.
- `select_in_ready` out 1: beat accepted when valid & ready.
- `select_clear` in 1: synchronous flush of the accumulation, output and histogram.
- `select_idx` out IW: nearest centroid index.
- `select_min` out DW: minimum distance.
- `select_out_valid` out 1: result held until accepted.
- `select_out_ready` in 1: consumer takes the result when valid & ready.
- `select_hist_sel` in IW: histogram read select (`NCS_HIST_EN` only).
- `select_hist_cnt` out CW: points assigned to centroid `select_hist_sel`, combinational read (`NCS_HIST_EN` only).

## Operation
Beat counter `cnt` (0..K-1), running `min`/`idx`, and one output register.

On an accepted beat:
- If `cnt==0`: `min<=dist`, `idx<=0`.
- Else if `dist<min` (strict): `min<=dist`, `idx<=cnt`.
- On equal distances the lower index wins.
- If `cnt==K-1`, the beat completes the point:
  - Final = (`dist<min` ? `dist`,`cnt` : `min`,`idx`); for `cnt==0` (K=1) final = `dist`, 0.
  - Final is loaded into the output register and `out_valid<=1`.
  - `cnt` wraps to 0.
- Otherwise `cnt<=cnt+1`.

Output state machine:
- EMPTY (`out_valid=0`) → FULL on completion.
- FULL → EMPTY when `out_ready` is high and there is no completion in the same cycle.
- FULL with `out_ready` and a completion in the same cycle: the output is overwritten and stays FULL.

Backpressure:
- `in_ready = !(out_valid && !out_ready && cnt==K-1)`.
- Accumulation of the next point continues while a result is held; only the completing beat stalls.

Arithmetic:
- Unsigned DW-bit compare; no overflow possible.
- `idx` has IW bits; `cnt` is compared against K-1.

Clear:
- `select_clear` forces `cnt=0`, `out_valid=0`, `min=0`, `idx=0`, and zeroes the histogram.
- Clear has priority over a simultaneous input beat; the beat is dropped.
- `in_ready` stays 1 during clear.

## Timing
- Reset (`select_rst`=0), asynchronous, all registers 0:
  - `select_out_valid=0`, `select_idx=0`, `select_min=0`.
  - `cnt=0`, `select_hist_cnt=0`.
  - `select_in_ready=1`.
- Latency: `out_valid` rises on the clock edge after the K-th beat is accepted (1 cycle).
- Throughput: one beat per cycle; one result per K cycles with no stall while `out_ready=1`.
- Reset mid-point: partial accumulation is discarded; the next beat is treated as centroid 0.
- `select_out_valid` never drops without `out_ready`, `clear`, or reset.
- `select_idx`/`select_min` are stable while `select_out_valid=1 && !select_out_ready`.

## Configuration
- `NCS_HIST_EN` defined:
  - K counters of CW bits, one per centroid.
  - `counter[final_idx]` increments when a result is loaded into the output register (at completion, not at handshake).
  - Counters saturate at all-ones.
  - Counters are cleared by reset or `select_clear`.
  - `select_hist_sel`/`select_hist_cnt` ports are present.
- `NCS_HIST_EN` undefined:
  - Counters and both histogram ports are absent.
  - Core behaviour is identical.

## Test plan
- K=4, `out_ready=1`, beats 169, 6400, 25, 900 → one cycle after the 4th beat, `out_valid=1`, `idx=2`, `min=25`; `out_valid` low the following cycle.
- Ties: beats 50, 50, 50, 50 → `idx=0`, `min=50`. Then 7, 3, 3, 9 → `idx=1`, `min=3`.
- Backpressure: `out_ready=0`, 8 continuous beats:
  - Point A: 9, 4, 16, 1 → held result `idx=3`, `min=1`.
  - Point B: 2, 8, 8, 8 → `in_ready` drops only at B's 4th beat.
  - After `out_ready` pulses high: A is consumed, B's last beat is accepted, and the next result is `idx=0`, `min=2`.
- Reset mid-point: reset asserted after 2 of 4 beats → all outputs 0 immediately. The next 4 beats 30, 20, 10, 40 → `idx=2`, `min=10`.
- Clear priority: `clear` and `in_valid` high together on the 3rd beat → beat dropped, no result. The following 4 beats form a fresh point.
- `NCS_HIST_EN`, CW=3, K=4: 9 points nearest to centroid 3 and 2 points nearest to centroid 1 → `hist_cnt[3]=7` (saturated), `hist_cnt[1]=2`, `hist_cnt[0]=0`. After `clear`, all counters read 0.
